xadc_axil_scan_scheduler: RTL

//  AXI4-Lite read-only master that periodically scans enabled XADC channel result registers in ascending order.

---
 rtl/xadc_axil_scan_scheduler.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/xadc_axil_scan_scheduler.sv
// rtl/xadc_axil_scan_scheduler.sv - periodic AXI4-Lite scan of XADC channel result registers
// Each enabled channel is read in ascending order and emitted as a 12-bit tagged stream sample.
module xadc_axil_scan_scheduler #(
   parameter int          N_CH               = 4,
   parameter int          C_M_AXI_ADDR_WIDTH = 32,
   parameter int          C_M_AXI_DATA_WIDTH = 32,
   parameter logic [31:0] XADC_BASE_ADDR     = 32'h43C0_0000,
   parameter logic [31:0] CH_REG_OFFSET      = 32'h0000_0200
) (
   input  logic                          ACLK,
   input  logic                          ARESETN,
   input  logic                          cfg_enable,
   input  logic [N_CH-1:0]               cfg_ch_mask,
   input  logic [31:0]                   cfg_period,
   input  logic                          cfg_err_clr,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [2:0]                    m_axi_arprot,
   output logic                          m_axi_arvalid,
   input  logic                          m_axi_arready,
   input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]                    m_axi_rresp,
   input  logic                          m_axi_rvalid,
   output logic                          m_axi_rready,
   output logic [11:0]                   m_axis_tdata,
   output logic [3:0]                    m_axis_tuser,
   output logic                          m_axis_tlast,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic                          busy,
   output logic                          err_slverr,
   output logic [15:0]                   overrun_cnt
);

   localparam logic [C_M_AXI_ADDR_WIDTH-1:0] REG0_ADDR =
      C_M_AXI_ADDR_WIDTH'(XADC_BASE_ADDR + CH_REG_OFFSET);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_TICK,
      S_ADDR,
      S_DATA,
      S_PUSH
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [31:0]     tick_cnt;
   logic [31:0]     period_m1;
   logic            tick;
   logic [N_CH-1:0] scan_mask;
   logic [N_CH-1:0] above_mask;
   logic [3:0]      ch;
   logic [3:0]      next_ch;
   logic            last_ch;
   logic            abort_q;
   logic [11:0]     sample_q;

   logic            latch_scan;
   logic            issue;
   logic [3:0]      issue_ch;
   logic            capture;
   logic            push_load;

   logic            unused_rdata;
   assign unused_rdata = ^{m_axi_rdata[C_M_AXI_DATA_WIDTH-1:16], m_axi_rdata[3:0]};

   function automatic logic [3:0] lowest_idx(input logic [N_CH-1:0] m);
      logic [3:0] idx;
      idx = '0;
      for (int k = N_CH - 1; k >= 0; k--) begin
         if (m[k]) idx = 4'(k);
      end
      return idx;
   endfunction

   // Periods of 0 and 1 both collapse to a compare value of 0, i.e. a tick every cycle.
   assign period_m1 = (cfg_period == 32'd0) ? 32'd0 : cfg_period - 32'd1;
   assign tick      = cfg_enable && (tick_cnt >= period_m1);

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         tick_cnt <= '0;
      end else if (!cfg_enable || tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 32'd1;
      end
   end

   always_comb begin
      above_mask = '0;
      for (int k = 0; k < N_CH; k++) begin
         above_mask[k] = scan_mask[k] && (k > int'(ch));
      end
   end

   assign next_ch = lowest_idx(above_mask);
   assign last_ch = ~|above_mask;

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      latch_scan = 1'b0;
      issue      = 1'b0;
      issue_ch   = ch;
      capture    = 1'b0;
      push_load  = 1'b0;
      case (state)
         S_IDLE: begin
            if (cfg_enable) state_nxt = S_WAIT_TICK;
         end
         S_WAIT_TICK: begin
            if (!cfg_enable) begin
               state_nxt = S_IDLE;
            end else if (tick && (|cfg_ch_mask)) begin
               latch_scan = 1'b1;
               issue      = 1'b1;
               issue_ch   = lowest_idx(cfg_ch_mask);
               state_nxt  = S_ADDR;
            end
         end
         S_ADDR: begin
            if (m_axi_arready) state_nxt = S_DATA;
         end
         S_DATA: begin
            // A read begun before cfg_enable fell still completes; its data is dropped.
            if (m_axi_rvalid) begin
               capture   = 1'b1;
               state_nxt = (abort_q || !cfg_enable) ? S_IDLE : S_PUSH;
            end
         end
         S_PUSH: begin
            if (!cfg_enable) begin
               state_nxt = S_IDLE;
            end else if (!m_axis_tvalid || m_axis_tready) begin
               push_load = 1'b1;
               if (last_ch) begin
                  state_nxt = S_WAIT_TICK;
               end else begin
                  issue     = 1'b1;
                  issue_ch  = next_ch;
                  state_nxt = S_ADDR;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign m_axi_arvalid = (state == S_ADDR);
   assign m_axi_rready  = (state == S_DATA);
   assign m_axi_arprot  = 3'b000;
   assign busy          = (state == S_ADDR) || (state == S_DATA) || (state == S_PUSH);

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         abort_q <= 1'b0;
      end else begin
         abort_q <= ((state == S_ADDR) || (state == S_DATA)) && (abort_q || !cfg_enable);
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         scan_mask     <= '0;
         ch            <= '0;
         m_axi_araddr  <= '0;
         sample_q      <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tuser  <= '0;
         m_axis_tlast  <= 1'b0;
      end else begin
         if (latch_scan) scan_mask <= cfg_ch_mask;
         if (issue) begin
            ch           <= issue_ch;
            m_axi_araddr <= REG0_ADDR + C_M_AXI_ADDR_WIDTH'({issue_ch, 2'b00});
         end
         if (capture) sample_q <= m_axi_rdata[15:4];
         if (push_load) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= sample_q;
            m_axis_tuser  <= ch;
            m_axis_tlast  <= last_ch;
         end else if (m_axis_tvalid && m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
         end
      end
   end

   // A new error beats a simultaneous clear so no SLVERR is ever lost.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         err_slverr <= 1'b0;
      end else if (capture && (m_axi_rresp != 2'b00)) begin
         err_slverr <= 1'b1;
      end else if (cfg_err_clr) begin
         err_slverr <= 1'b0;
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         overrun_cnt <= '0;
      end else if (tick && busy && (overrun_cnt != 16'hFFFF)) begin
         overrun_cnt <= overrun_cnt + 16'd1;
      end
   end

endmodule
